hist_update: RTL

HIST_UPDATE -- requirements
Module: hist_update

---
 rtl/hist_pkg.sv | 12 +
 rtl/hist_onehot_dec.sv | 14 +
 rtl/hist_update.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram update block: counter width, default
// bin count and the sweep FSM state encoding.
package hist_pkg;
  localparam int CNT_W        = 32;
  localparam int NUM_BINS_DEF = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } hist_state_e;
endpackage

// File: rtl/hist_onehot_dec.sv
// Bin index to one-hot bank write-enable decoder; all-zero when en is low.
module hist_onehot_dec #(
  parameter int NUM_BINS = 16,
  parameter int BIN_W    = $clog2(NUM_BINS)
) (
  input  logic                en,
  input  logic [BIN_W-1:0]    idx,
  output logic [NUM_BINS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/hist_update.sv
// Histogram bin incrementer with a two-stage read-modify-write pipeline into an
// external register bank, plus a drain-then-zero sweep. Define HIST_SAT_EN for saturating counters.
//
// Handshake: a sample transfers on a rising clk edge where in_valid && in_ready;
// in_ready depends only on FSM state (high in RUN), never on in_valid.
module hist_update
  import hist_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int BIN_W    = $clog2(NUM_BINS)
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          in_bin,
  input  logic                      sweep_start,
  output logic                      sweep_busy,
  output logic                      sweep_done,
  input  logic [NUM_BINS*CNT_W-1:0] bank_q,
  output logic [NUM_BINS-1:0]       bank_we,
  output logic [CNT_W-1:0]          bank_d,
  output logic                      sat_flag,
  output hist_state_e               state_dbg
);
  hist_state_e state, state_nxt;

  logic                s1_valid, s2_valid;
  logic [BIN_W-1:0]    s1_bin, s2_bin, sweep_cnt;
  logic [CNT_W-1:0]    bank_arr [NUM_BINS];
  logic [CNT_W-1:0]    cnt_src, cnt_inc;
  logic                accept, sweep_last;
  logic                dec_en;
  logic [BIN_W-1:0]    dec_idx;
  logic [NUM_BINS-1:0] dec_onehot;

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_unpack
    assign bank_arr[g] = bank_q[g*CNT_W +: CNT_W];
  end

  // S2 holds a write the bank has not committed yet, so a same-bin S1 must use it.
  assign cnt_src = (s2_valid && (s2_bin == s1_bin)) ? bank_d : bank_arr[s1_bin];

`ifdef HIST_SAT_EN
  logic sat_hit;
  assign sat_hit = s1_valid && (cnt_src == '1);
  assign cnt_inc = (cnt_src == '1) ? cnt_src : cnt_src + CNT_W'(1);
`else
  assign cnt_inc = cnt_src + CNT_W'(1);
`endif

  assign accept     = in_valid && in_ready;
  assign sweep_last = (sweep_cnt == BIN_W'(NUM_BINS - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    sweep_busy = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        if (sweep_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        sweep_busy = 1'b1;
        if (!s1_valid && !s2_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        sweep_busy = 1'b1;
        if (sweep_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // No samples are accepted outside RUN, so S1 and the sweep never share the decoder.
  assign dec_en  = s1_valid || (state == CLEAR);
  assign dec_idx = s1_valid ? s1_bin : sweep_cnt;

  hist_onehot_dec #(
    .NUM_BINS (NUM_BINS),
    .BIN_W    (BIN_W)
  ) u_dec (
    .en     (dec_en),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      bank_we  <= '0;
      bank_d   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_bin <= in_bin;
      s2_valid <= s1_valid;
      if (s1_valid) s2_bin <= s1_bin;
      bank_we  <= dec_onehot;
      bank_d   <= s1_valid ? cnt_inc : '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sweep_cnt  <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= (state == CLEAR) && sweep_last;
      if (state == CLEAR) sweep_cnt <= sweep_cnt + BIN_W'(1);
      else                sweep_cnt <= '0;
    end
  end

`ifdef HIST_SAT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                               sat_flag <= 1'b0;
    else if ((state == CLEAR) && sweep_last)  sat_flag <= 1'b0;
    else if (sat_hit)                         sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif
endmodule
